// File: rtl/stopwatch_pkg.sv
// Shared state encoding and command indices for the stopwatch front panel.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_PAUSE    = 3'd2,
      ST_LAP_VIEW = 3'd3,
      ST_CLEAR    = 3'd4
   } state_e;

   localparam int unsigned PULSE_CYCLES_DEF = 4;

   localparam int unsigned NCMD      = 4;
   localparam int unsigned CMD_START = 0;
   localparam int unsigned CMD_STOP  = 1;
   localparam int unsigned CMD_LAP   = 2;
   localparam int unsigned CMD_CLR   = 3;

   typedef logic [NCMD-1:0] cmd_t;

endpackage

// File: rtl/button_debounce.sv
// Raw button to debounced level and single-cycle press strobe.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [1:0]    sync_q;
   logic [1:0]    vld_q;
   logic          arm_q, arm_d;
   logic          lvl_q, lvl_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Presses are only armed once a released level is seen after reset,
   // so a button held through reset cannot fire on its own.
   always_comb begin
      cnt_d   = '0;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      arm_d   = arm_q | (vld_q[1] & ~sync_q[1]);
      if (sync_q[1] != lvl_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            lvl_d   = sync_q[1];
            press_d = sync_q[1] & arm_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         vld_q   <= '0;
         arm_q   <= 1'b0;
         lvl_q   <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         vld_q   <= {vld_q[0], 1'b1};
         arm_q   <= arm_d;
         lvl_q   <= lvl_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Front-panel sequencer: debounced buttons, mode FSM, command pulses
// and the lap display hold timer.
module stopwatch_ctrl_fsm
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned TICK_CYCLES     = 100_000,
   parameter int unsigned LAP_HOLD_MS     = 3000,
   parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lap,
   output logic       start,
   output logic       stop,
   output logic       lap,
   output logic       clr,
   output logic       disp_lap,
   output logic [2:0] state,
   output logic       busy
);

   localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
   localparam int unsigned TW =
      (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned HW =
      (LAP_HOLD_MS > 1) ? $clog2(LAP_HOLD_MS) : 1;

   logic          ss_press, lap_press;
   logic          ss_ok, lap_ok;
   state_e        state_q, state_d;
   cmd_t          cmd_q, cmd_d, cmd_new;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          busy_q, busy_d;
   logic          disp_q, disp_d;
   logic [TW-1:0] pre_q, pre_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          tick_q, tick_d;
   logic          expire, restart;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_ss (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_ss),
      .press_o(ss_press)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_lap (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_lap),
      .press_o(lap_press)
   );

   // Presses during a pulse are dropped; ss beats lap on a tie.
   assign ss_ok  = ss_press & ~busy_q;
   assign lap_ok = lap_press & ~busy_q & ~ss_press;

   always_comb begin
      state_d = state_q;
      cmd_new = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (ss_ok) begin
               state_d            = ST_RUN;
               cmd_new[CMD_START] = 1'b1;
            end
         end
         ST_RUN: begin
            if (ss_ok) begin
               state_d           = ST_PAUSE;
               cmd_new[CMD_STOP] = 1'b1;
            end else if (lap_ok) begin
               state_d          = ST_LAP_VIEW;
               cmd_new[CMD_LAP] = 1'b1;
            end
         end
         ST_LAP_VIEW: begin
            if (ss_ok) begin
               state_d           = ST_PAUSE;
               cmd_new[CMD_STOP] = 1'b1;
            end else if (lap_ok) begin
               cmd_new[CMD_LAP] = 1'b1;
            end else if (expire) begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (ss_ok) begin
               state_d            = ST_RUN;
               cmd_new[CMD_START] = 1'b1;
            end else if (lap_ok) begin
               state_d          = ST_CLEAR;
               cmd_new[CMD_CLR] = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (pcnt_q == PW'(1)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pcnt_d = pcnt_q;
      cmd_d  = cmd_q;
      if (cmd_new != '0) begin
         pcnt_d = PW'(PULSE_CYCLES);
         cmd_d  = cmd_new;
      end else if (pcnt_q != '0) begin
         pcnt_d = pcnt_q - 1'b1;
         if (pcnt_q == PW'(1)) begin
            cmd_d = '0;
         end
      end
   end

   assign busy_d = (pcnt_d != '0);
   assign disp_d = (state_d == ST_LAP_VIEW);

   // Tick is registered, so expiry lands one clock after the last tick.
   assign restart = cmd_new[CMD_LAP];
   assign expire  = tick_q & (hold_q == HW'(LAP_HOLD_MS - 1));

   always_comb begin
      pre_d  = '0;
      hold_d = '0;
      tick_d = 1'b0;
      if (state_q == ST_LAP_VIEW && !restart) begin
         if (pre_q == TW'(TICK_CYCLES - 1)) begin
            tick_d = 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
         hold_d = hold_q;
         if (tick_q) begin
            hold_d = expire ? '0 : hold_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         pcnt_q  <= '0;
         busy_q  <= 1'b0;
         disp_q  <= 1'b0;
         pre_q   <= '0;
         hold_q  <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         pcnt_q  <= pcnt_d;
         busy_q  <= busy_d;
         disp_q  <= disp_d;
         pre_q   <= pre_d;
         hold_q  <= hold_d;
         tick_q  <= tick_d;
      end
   end

   assign start    = cmd_q[CMD_START];
   assign stop     = cmd_q[CMD_STOP];
   assign lap      = cmd_q[CMD_LAP];
   assign clr      = cmd_q[CMD_CLR];
   assign disp_lap = disp_q;
   assign state    = state_q;
   assign busy     = busy_q;

endmodule

// File: doc/stopwatch_ctrl_fsm.md
# stopwatch_ctrl_fsm

Front-panel sequencer for the four-digit stopwatch. It takes two raw pushbuttons (start/stop and lap/reset), debounces them, and runs a mode state machine. The state machine issues correctly shaped start, stop, lap and clr pulses to the stopwatch core, and drives the display select that shows either live time or the frozen lap value. It sits between the board buttons and the stopwatch top, beside the display driver.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles before a button level is accepted (10 ms at 100 MHz).
- TICK_CYCLES, default 100_000: clocks per 1 ms hold-timer tick.
- LAP_HOLD_MS, default 3000: milliseconds a lap value stays on the display.
- PULSE_CYCLES, default 4: high time of every command pulse. Must be ≥ 2.

Ports:
- clk, input, 1: 100 MHz system clock.
- rst, input, 1: asynchronous, active-high reset.
- btn_ss, input, 1: raw start/stop button, asynchronous to clk.
- btn_lap, input, 1: raw lap/reset button, asynchronous to clk.
- start, output, 1: start command pulse to the stopwatch.
- stop, output, 1: stop command pulse.
- lap, output, 1: lap-capture command pulse.
- clr, output, 1: clear command pulse.
- disp_lap, output, 1: 1 = display shows lap registers; 0 = display shows live counters.
- state, output, 3: current FSM state, for LEDs and debug.
- busy, output, 1: a command pulse is in progress.

## Operation
- Button path, one instance per button:
  - Two-flop synchronizer feeds a debounce counter.
  - The debounced level changes after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A press event is a one-cycle strobe on the debounced rising edge. Releases generate nothing.
- State encoding: IDLE=0, RUN=1, PAUSE=2, LAP_VIEW=3, CLEAR=4.
- IDLE:
  - ss press → assert start, go to RUN.
  - lap press → ignored.
- RUN:
  - ss press → assert stop, go to PAUSE.
  - lap press → assert lap, go to LAP_VIEW, restart the hold timer.
- LAP_VIEW (counter keeps running, disp_lap=1):
  - Hold expiry → go to RUN.
  - lap press → assert lap again, restart the hold timer.
  - ss press → assert stop, go to PAUSE.
- PAUSE:
  - ss press → assert start, go to RUN.
  - lap press → assert clr, go to CLEAR.
- CLEAR: when the clr pulse ends, go to IDLE.
- disp_lap is 1 only in LAP_VIEW.
- Command pulses:
  - A single shared pulse counter drives them; at most one command is high at a time.
  - busy = pulse counter non-zero.
  - Press events arriving while busy=1 are dropped, not queued.
- Simultaneous ss and lap press events in one cycle: ss wins, lap is dropped.
- Hold timer:
  - A prescaler counts 0..TICK_CYCLES-1 and produces a 1 ms tick.
  - A hold counter counts ticks 0..LAP_HOLD_MS-1.
  - Both clear on every entry to, or re-lap within, LAP_VIEW.
  - Expiry is the tick on which the hold count equals LAP_HOLD_MS-1.
  - Widths are $clog2 of each limit; no wrap occurs outside LAP_VIEW because the counters are held at 0.
- Reset (asynchronous, at any time, including mid-pulse or mid-hold):
  - state=IDLE; start=stop=lap=clr=0; disp_lap=0; busy=0.
  - All counters cleared; debounced levels 0; synchronizers 0.
  - A pulse in progress is truncated immediately.
  - A button held through reset release produces no press until released and pressed again, because the debounced level must first settle high from 0. It then yields exactly one press.

## Timing
- Raw button stable high from cycle 0:
  - Debounced level rises at cycle DEBOUNCE_CYCLES+2.
  - FSM state and command output register at cycle DEBOUNCE_CYCLES+3.
- Command pulse: high for exactly PULSE_CYCLES clocks, asserted on the same edge as the state change, then low.
  - The stopwatch's 2-flop edge detector therefore sees exactly one rising edge.
- busy: rises with the pulse, falls on the edge the pulse falls.
  - A press event in that falling cycle is accepted.
- CLEAR→IDLE: occurs on the edge the clr pulse falls.
- Hold expiry: LAP_VIEW→RUN and disp_lap 1→0 on the edge after the expiry tick.
  - Total hold = LAP_HOLD_MS × TICK_CYCLES + 1 clocks after entry.
  - A re-lap restarts this count from its own entry edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package stopwatch_pkg holds:
  - state enum/localparams IDLE..CLEAR (3 bits);
  - default PULSE_CYCLES;
  - command index constants.
- Sub-module button_debounce (synchronizer, debounce counter, press strobe; parameter DEBOUNCE_CYCLES) is instantiated twice.
- FSM, pulse generator and hold timer live in stopwatch_ctrl_fsm.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TICK_CYCLES=10, LAP_HOLD_MS=3, PULSE_CYCLES=4.
- Bounce rejection: btn_ss toggling every 2 cycles for 20 cycles, then stable high → exactly one start pulse of 4 cycles; state IDLE→RUN at 7 cycles after the stable high begins.
- Full cycle: ss, lap, wait, ss, lap → pulses start, lap, stop, clr in order; state sequence 0,1,3,1,2,4,0; disp_lap high for exactly 31 cycles.
- Re-lap: second lap press 15 cycles into LAP_VIEW → second lap pulse; LAP_VIEW lasts 31 cycles from the second entry.
- Collision and busy: ss and lap strobes in the same cycle in RUN → stop only, state=2. A lap press 2 cycles after that stop pulse starts (busy) → dropped, state stays 2.
- Reset mid-pulse: rst asserted during cycle 2 of a start pulse → start=0 immediately, state=0. Button held through reset release → no pulse until re-pressed.
- Pulse shape: every command output, checked with an assertion, is high for exactly 4 consecutive cycles, and no two commands are ever high together.
